tm1638_key_debounce: RTL

//  Downstream of the TM1638 8-key/8-digit/8-LED panel driver. Takes its raw sw0..sw7 key bits,

---
 rtl/tm1638_key_debounce.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/tm1638_key_debounce.sv
// TM1638 key post-processing: synchronises the raw sw bits, debounces them on a
// divided sample tick, and produces per-key edge, repeat and toggle outputs plus
// a lowest-index event code for the CPU side.

// Per-key debounce, edge-pulse, toggle and auto-repeat logic.
module tm1638_key_lane #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sw_s,
  output logic key_st,
  output logic press_p,
  output logic release_p,
  output logic repeat_p,
  output logic toggle_q
);
  localparam int CW   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_RATE   = RW'(REPEAT_RATE);
  localparam logic [RW-1:0] R_ONE    = RW'(1);

  logic [CW-1:0] cnt;
  logic [RW-1:0] rcnt;
  logic          accept;

  // A new level is accepted on the tick where the disagreement count saturates.
  assign accept = tick && (sw_s != key_st) && (cnt == CNT_LAST);

  // Debounce counter, debounced level, edge pulses and toggle latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      key_st    <= 1'b0;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      press_p   <= 1'b0;
      release_p <= 1'b0;
      if (tick) begin
        if (sw_s == key_st) begin
          cnt <= '0;
        end else if (accept) begin
          key_st    <= sw_s;
          cnt       <= '0;
          press_p   <= sw_s;
          release_p <= ~sw_s;
          if (sw_s) toggle_q <= ~toggle_q;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Auto-repeat countdown: armed on press, cleared on release, paced by ticks.
  // A press only happens from key_st=0, so repeat can never coincide with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt     <= '0;
      repeat_p <= 1'b0;
    end else begin
      repeat_p <= 1'b0;
      if (accept) begin
        rcnt <= sw_s ? R_DELAY : '0;
      end else if (tick && key_st && (rcnt != '0)) begin
        if (rcnt == R_ONE) begin
          repeat_p <= 1'b1;
          rcnt     <= R_RATE;
        end else begin
          rcnt <= rcnt - R_ONE;
        end
      end
    end
  end
endmodule

module tm1638_key_debounce #(
  parameter int TICK_DIVIDER   = 1000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  output logic [7:0] key_state,
  output logic [7:0] key_press,
  output logic [7:0] key_release,
  output logic [7:0] key_repeat,
  output logic [7:0] key_toggle,
  output logic       event_valid,
  output logic [2:0] event_key
);
  localparam int NUM_KEYS = 8;
  localparam int TW       = $clog2(TICK_DIVIDER + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIVIDER - 1);

  logic [NUM_KEYS-1:0] sw_m, sw_s, ev;
  logic [TW-1:0]       tick_cnt;
  logic                tick;

  // Two-flop synchroniser on the raw key bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      sw_m <= sw;
      sw_s <= sw_m;
    end
  end

  // Down-counting sample-tick divider; tick is high while the count sits at 0.
  always_ff @(posedge clk) begin
    if (rst)                tick_cnt <= TICK_LAST;
    else if (tick_cnt == '0) tick_cnt <= TICK_LAST;
    else                    tick_cnt <= tick_cnt - TW'(1);
  end

  assign tick = (tick_cnt == '0);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    tm1638_key_lane #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_RATE   (REPEAT_RATE)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .sw_s     (sw_s[i]),
      .key_st   (key_state[i]),
      .press_p  (key_press[i]),
      .release_p(key_release[i]),
      .repeat_p (key_repeat[i]),
      .toggle_q (key_toggle[i])
    );
  end

  assign ev = key_press | key_repeat;

  // Lowest-index priority encode of press/repeat pulses; extra keys are dropped.
  always_comb begin
    event_valid = |ev;
    event_key   = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (ev[i]) event_key = 3'(i);
  end
endmodule
